// File: rtl/scan_test_pkg.sv
// Shared definitions for the scan test controller: FSM encoding, MISR taps, counter sizing.
package scan_test_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CAPTURE,
        S_UNLOAD,
        S_LOAD_UNLOAD
    } state_e;

    function automatic int unsigned cnt_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

    // Internal-XOR feedback taps (bit k set = XOR feedback into bit k); primitive polynomials.
    function automatic logic [31:0] misr_taps(input int unsigned n);
        case (n)
            1:       return 32'h0000_0001;
            2:       return 32'h0000_0003;
            3:       return 32'h0000_0003;
            4:       return 32'h0000_0003;
            5:       return 32'h0000_0005;
            6:       return 32'h0000_0003;
            7:       return 32'h0000_0003;
            8:       return 32'h0000_001d;
            default: return 32'h0000_0003;
        endcase
    endfunction

endpackage

// File: rtl/scan_misr.sv
// Serial-input MISR compacting unloaded scan data; only instantiated when SCAN_MISR_EN is defined.
module scan_misr
    import scan_test_pkg::*;
#(
    parameter int unsigned WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             din,
    output logic [WIDTH-1:0] sig
);

    localparam logic [WIDTH-1:0] TAPS = WIDTH'(misr_taps(WIDTH));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig <= '0;
        end else if (en) begin
            sig <= (sig << 1) ^ (sig[WIDTH-1] ? TAPS : '0) ^ WIDTH'(din);
        end
    end

endmodule

// File: rtl/scan_test_controller.sv
// Tester-side scan driver: load, capture, unload and compare one pattern at a time with overlap.
// Define SCAN_MISR_EN to compact every unloaded bit (XOR captured PO) into the signature output.
module scan_test_controller
    import scan_test_pkg::*;
#(
    parameter int unsigned CHAIN_LEN = 2,
    parameter int unsigned PI_W      = 1,
    parameter int unsigned PO_W      = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pat_valid,
    output logic                 pat_ready,
    input  logic [CHAIN_LEN-1:0] pat_load,
    input  logic [PI_W-1:0]      pat_pi,
    input  logic [CHAIN_LEN-1:0] pat_exp_resp,
    input  logic [PO_W-1:0]      pat_exp_po,
    output logic                 tm,
    output logic                 si,
    output logic [PI_W-1:0]      pi,
    input  logic                 so,
    input  logic [PO_W-1:0]      po,
    output logic                 busy,
    output logic                 res_valid,
    output logic                 res_pass,
    output logic [CHAIN_LEN-1:0] res_resp,
    output logic [PO_W-1:0]      res_po,
    output logic [CHAIN_LEN-1:0] signature
);

    localparam int unsigned CW = cnt_width(CHAIN_LEN);

    state_e               state;
    logic [CW-1:0]        cnt;
    logic [CHAIN_LEN-1:0] ld_sh;
    logic [CHAIN_LEN-1:0] unl_sh;
    logic [CHAIN_LEN-1:0] pend_exp_resp;
    logic [CHAIN_LEN-1:0] unl_exp_resp;
    logic [PI_W-1:0]      pend_pi;
    logic [PO_W-1:0]      pend_exp_po;
    logic [PO_W-1:0]      unl_exp_po;
    logic [PO_W-1:0]      po_cap;
    logic                 hs_c;
    logic                 last_c;
    logic                 unloading_c;
    logic [CHAIN_LEN-1:0] resp_next_c;

    assign hs_c        = pat_valid & pat_ready;
    assign last_c      = (cnt == CW'(CHAIN_LEN - 1));
    assign unloading_c = (state == S_UNLOAD) || (state == S_LOAD_UNLOAD);
    // First unloaded bit ends up in the MSB (cell CHAIN_LEN-1).
    assign resp_next_c = CHAIN_LEN'({unl_sh, so});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_pi       <= '0;
            pend_exp_resp <= '0;
            pend_exp_po   <= '0;
        end else if (hs_c) begin
            pend_pi       <= pat_pi;
            pend_exp_resp <= pat_exp_resp;
            pend_exp_po   <= pat_exp_po;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            cnt          <= '0;
            ld_sh        <= '0;
            unl_sh       <= '0;
            unl_exp_resp <= '0;
            unl_exp_po   <= '0;
            po_cap       <= '0;
            pat_ready    <= 1'b0;
            tm           <= 1'b0;
            si           <= 1'b0;
            pi           <= '0;
            busy         <= 1'b0;
            res_valid    <= 1'b0;
            res_pass     <= 1'b0;
            res_resp     <= '0;
            res_po       <= '0;
        end else begin
            res_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    pat_ready <= 1'b1;
                    if (hs_c) begin
                        state     <= S_LOAD;
                        cnt       <= '0;
                        tm        <= 1'b1;
                        si        <= pat_load[CHAIN_LEN-1];
                        ld_sh     <= pat_load << 1;
                        busy      <= 1'b1;
                        pat_ready <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (last_c) begin
                        state     <= S_CAPTURE;
                        tm        <= 1'b0;
                        si        <= 1'b0;
                        pi        <= pend_pi;
                        pat_ready <= 1'b1;
                    end else begin
                        cnt   <= cnt + CW'(1);
                        si    <= ld_sh[CHAIN_LEN-1];
                        ld_sh <= ld_sh << 1;
                    end
                end
                S_CAPTURE: begin
                    // Expected values move to the unload slot before a new pattern overwrites them.
                    po_cap       <= po;
                    unl_exp_resp <= pend_exp_resp;
                    unl_exp_po   <= pend_exp_po;
                    cnt          <= '0;
                    tm           <= 1'b1;
                    pat_ready    <= 1'b0;
                    if (hs_c) begin
                        state <= S_LOAD_UNLOAD;
                        si    <= pat_load[CHAIN_LEN-1];
                        ld_sh <= pat_load << 1;
                    end else begin
                        state <= S_UNLOAD;
                        si    <= 1'b0;
                    end
                end
                S_UNLOAD, S_LOAD_UNLOAD: begin
                    unl_sh <= resp_next_c;
                    if (last_c) begin
                        res_valid <= 1'b1;
                        res_resp  <= resp_next_c;
                        res_po    <= po_cap;
                        res_pass  <= (resp_next_c == unl_exp_resp) && (po_cap == unl_exp_po);
                        tm        <= 1'b0;
                        si        <= 1'b0;
                        pat_ready <= 1'b1;
                        if (state == S_UNLOAD) begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= S_CAPTURE;
                            pi    <= pend_pi;
                        end
                    end else begin
                        cnt   <= cnt + CW'(1);
                        si    <= (state == S_LOAD_UNLOAD) ? ld_sh[CHAIN_LEN-1] : 1'b0;
                        ld_sh <= ld_sh << 1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef SCAN_MISR_EN
    scan_misr #(
        .WIDTH(CHAIN_LEN)
    ) u_misr (
        .clk(clk),
        .rst(rst),
        .en (unloading_c),
        .din(so ^ (^po_cap)),
        .sig(signature)
    );
`else
    assign signature = '0;
`endif

endmodule

// File: tb/tb_scan_test_controller.sv
// Self-checking bench: behavioural two-cell scan core plus scoreboard of predicted results.
module tb_scan_test_controller;

    localparam int unsigned CL = 2;
`ifdef SCAN_MISR_EN
    localparam bit MISR_ON = 1'b1;
`else
    localparam bit MISR_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          pat_valid = 1'b0;
    logic          pat_ready;
    logic [CL-1:0] pat_load = '0;
    logic [0:0]    pat_pi = '0;
    logic [CL-1:0] pat_exp_resp = '0;
    logic [0:0]    pat_exp_po = '0;
    logic          tm, si, so, busy, res_valid, res_pass;
    logic [0:0]    pi, po, res_po;
    logic [CL-1:0] res_resp, signature;

    typedef struct {
        logic [1:0] resp;
        logic       po;
        logic       pass;
        int         stamp;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    logic [1:0] cells;
    logic [1:0] model_sig = '0;

    scan_test_controller #(.CHAIN_LEN(CL), .PI_W(1), .PO_W(1)) dut (
        .clk(clk), .rst(rst), .pat_valid(pat_valid), .pat_ready(pat_ready),
        .pat_load(pat_load), .pat_pi(pat_pi), .pat_exp_resp(pat_exp_resp),
        .pat_exp_po(pat_exp_po), .tm(tm), .si(si), .pi(pi), .so(so), .po(po),
        .busy(busy), .res_valid(res_valid), .res_pass(res_pass),
        .res_resp(res_resp), .res_po(res_po), .signature(signature)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Core under test: cell0=qB, cell1=qC; qB'=pi&qB, qC'=~(pi|qB), po=~(pi|qC).
    always @(posedge clk or posedge rst) begin
        if (rst)     cells <= '0;
        else if (tm) cells <= {cells[0], si};
        else         cells <= {~(pi[0] | cells[0]), pi[0] & cells[0]};
    end
    assign so = cells[1];
    assign po = ~(pi | cells[1]);

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic exp_t predict(input logic [1:0] load, input logic p,
                                     input logic [1:0] er, input logic ep);
        exp_t e;
        e.resp  = {~(p | load[0]), p & load[0]};
        e.po    = ~(p | load[1]);
        e.pass  = (e.resp == er) && (e.po == ep);
        e.stamp = 0;
        return e;
    endfunction

    // x^2+x+1 internal-XOR MISR, one step per unloaded bit.
    function automatic logic [1:0] misr_step(input logic [1:0] s, input logic d);
        logic [1:0] n;
        n = {s[0], 1'b0} ^ {d ^ 1'b0, d} & 2'b01;
        n = {s[0], d} ^ (s[1] ? 2'b11 : 2'b00);
        return n;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            model_sig = '0;
        end else if (res_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_res_valid", 32'(res_valid), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("res_resp", 32'(res_resp), 32'(e.resp));
                check("res_po", 32'(res_po), 32'(e.po));
                check("res_pass", 32'(res_pass), 32'(e.pass));
                check("latency", 32'(cyc - e.stamp), 32'(2 * CL + 1));
                model_sig = misr_step(model_sig, e.resp[1] ^ e.po);
                model_sig = misr_step(model_sig, e.resp[0] ^ e.po);
                check("signature", 32'(signature), MISR_ON ? 32'(model_sig) : 32'd0);
            end
        end
    end

    task automatic send(input logic [1:0] load, input logic p,
                        input logic [1:0] er, input logic ep);
        exp_t e;
        bit   hs;
        hs = 1'b0;
        @(negedge clk);
        pat_valid    = 1'b1;
        pat_load     = load;
        pat_pi       = p;
        pat_exp_resp = er;
        pat_exp_po   = ep;
        for (int i = 0; i < 50 && !hs; i++) begin
            if (pat_ready) hs = 1'b1;
            @(posedge clk);
            #1;
        end
        if (!hs) begin
            check("accept_timeout", 32'd0, 32'd1);
        end else begin
            e       = predict(load, p, er, ep);
            e.stamp = cyc;
            sb.push_back(e);
        end
    endtask

    task automatic drain();
        @(negedge clk);
        pat_valid = 1'b0;
        for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
        check("drain", 32'(sb.size()), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #12;
        check("rst_tm", 32'(tm), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'(pat_ready), 32'd0);
        check("rst_res", 32'({res_valid, res_pass, res_resp, res_po}), 32'd0);
        check("rst_sig", 32'(signature), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Pattern 1 with explicit si order (pat_load[1] first, then pat_load[0]).
        send(2'b01, 1'b1, 2'b01, 1'b0);
        check("p1_si0", 32'(si), 32'd0);
        check("p1_tm", 32'(tm), 32'd1);
        check("p1_busy", 32'(busy), 32'd1);
        @(negedge clk);
        pat_valid = 1'b0;
        @(posedge clk);
        #1;
        check("p1_si1", 32'(si), 32'd1);
        drain();
        check("idle_busy", 32'(busy), 32'd0);

        send(2'b01, 1'b0, 2'b00, 1'b1);
        drain();
        send(2'b01, 1'b1, 2'b11, 1'b0);
        drain();

        // Back-to-back: second pattern accepted during CAPTURE.
        send(2'b10, 1'b1, 2'b10, 1'b0);
        send(2'b11, 1'b0, 2'b00, 1'b0);
        drain();

        // Reset in the second LOAD cycle discards the pattern.
        send(2'b11, 1'b1, 2'b11, 1'b0);
        @(negedge clk);
        pat_valid = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_tm", 32'(tm), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_sig", 32'(signature), 32'd0);
        sb.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        check("no_stale_result", 32'(sb.size()), 32'd0);

        send(2'b10, 1'b0, 2'b00, 1'b1);
        drain();

        // Random back-to-back stream.
        for (int k = 0; k < 4; k++) begin
            logic [1:0] l;
            logic [1:0] er;
            logic       p;
            l  = 2'($urandom_range(0, 3));
            p  = 1'($urandom_range(0, 1));
            er = 2'($urandom_range(0, 3));
            send(l, p, er, 1'($urandom_range(0, 1)));
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
